// File: rtl/m_stall_memory.sv
// Single-port word memory that stalls the requester for a fixed read/write latency,
// with a direct one-cycle init write path used before normal operation begins.
module m_stall_memory #(
    parameter int unsigned ADDR_WIDTH    = 9,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_init_done,
    input  logic [DATA_WIDTH/8-1:0]   i_init_wen,
    input  logic [ADDR_WIDTH-1:0]     i_init_addr,
    input  logic [DATA_WIDTH-1:0]     i_init_data,
    input  logic                      i_ren,
    input  logic [DATA_WIDTH/8-1:0]   i_wen,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0]     i_data,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      o_stall,
    output logic                      o_valid
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_W    = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'((WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;
    logic                    o_valid_q, o_valid_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH] = '{default: '0};

    logic                    req;
    logic                    req_wr;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [BE_WIDTH-1:0]     mem_be;

    assign req    = i_ren | (|i_wen);
    assign req_wr = |i_wen;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        wr_d    = wr_q;
        unique case (state_q)
            IDLE: begin
                if (i_init_done && req) begin
                    addr_d = i_addr;
                    data_d = i_data;
                    be_d   = i_wen;
                    wr_d   = req_wr;
                    if ((req_wr && WRITE_LATENCY == 1) || (!req_wr && READ_LATENCY == 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = req_wr ? WR_CNT : RD_CNT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A latency-1 request enters DONE straight from IDLE, before addr_q is loaded.
    assign rd_addr = (state_q == IDLE) ? i_addr : addr_q;

    always_comb begin
        o_data_d  = o_data_q;
        o_valid_d = (state_d == DONE);
        if (state_d == DONE) o_data_d = mem_q[rd_addr];
    end

    assign o_stall = ((state_q == IDLE) && req) || (state_q == WAIT) || !i_init_done;
    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            wr_q      <= 1'b0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            wr_q      <= wr_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
        end
    end

    // Request writes commit on the edge leaving DONE, after the read-back was registered.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        mem_be    = be_q;
        if (state_q == DONE && wr_q) begin
            mem_we = 1'b1;
        end else if (state_q == IDLE && !i_init_done && (|i_init_wen)) begin
            mem_we    = 1'b1;
            mem_addr  = i_init_addr;
            mem_wdata = i_init_data;
            mem_be    = i_init_wen;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int unsigned k = 0; k < BE_WIDTH; k++) begin
                if (mem_be[k]) mem_q[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_m_stall_memory.sv
// Scoreboard bench for m_stall_memory: expected read-back data is queued when a
// request is driven and compared when o_valid fires.
module tb_m_stall_memory;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_init_done = 1'b1;
    logic [3:0]  i_init_wen = '0;
    logic [8:0]  i_init_addr = '0;
    logic [31:0] i_init_data = '0;
    logic        i_ren = 1'b0;
    logic [3:0]  i_wen = '0;
    logic [8:0]  i_addr = '0;
    logic [31:0] i_data = '0;
    logic [31:0] o_data;
    logic        o_stall;
    logic        o_valid;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q[$];

    m_stall_memory #(
        .ADDR_WIDTH   (9),
        .DATA_WIDTH   (32),
        .READ_LATENCY (4),
        .WRITE_LATENCY(2)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_init_done(i_init_done),
        .i_init_wen (i_init_wen),
        .i_init_addr(i_init_addr),
        .i_init_data(i_init_data),
        .i_ren      (i_ren),
        .i_wen      (i_wen),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_stall    (o_stall),
        .o_valid    (o_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
            else                   check("rdata", o_data, exp_q.pop_front());
        end
    end

    // Drives one request, holds it while stalled, and checks the stall/valid timeline.
    task automatic do_req(input logic ren, input logic [3:0] wen, input logic [8:0] addr,
                          input logic [31:0] data, input int lat, input logic [31:0] exp_rd);
        @(posedge i_clk); #1;
        i_ren  = ren;
        i_wen  = wen;
        i_addr = addr;
        i_data = data;
        exp_q.push_back(exp_rd);
        for (int c = 0; c < lat; c++) begin
            @(negedge i_clk);
            check("stall_busy", {31'd0, o_stall}, 32'd1);
            check("valid_busy", {31'd0, o_valid}, 32'd0);
        end
        @(negedge i_clk);
        check("stall_done", {31'd0, o_stall}, 32'd0);
        check("valid_done", {31'd0, o_valid}, 32'd1);
        @(posedge i_clk); #1;
        i_ren = 1'b0;
        i_wen = '0;
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_data",  o_data, 32'd0);

        do_req(1'b0, 4'hF, 9'd5, 32'hDEADBEEF, 2, 32'h0);
        do_req(1'b1, 4'h0, 9'd5, 32'h0,        4, 32'hDEADBEEF);
        do_req(1'b0, 4'b0001, 9'd5, 32'h000000AA, 2, 32'hDEADBEEF);
        do_req(1'b1, 4'h0, 9'd5, 32'h0,        4, 32'hDEADBEAA);
        do_req(1'b1, 4'hF, 9'd5, 32'h00000001, 2, 32'hDEADBEAA);
        do_req(1'b1, 4'h0, 9'd5, 32'h0,        4, 32'h00000001);
        do_req(1'b0, 4'b1010, 9'd0, 32'hA1B2C3D4, 2, 32'h0);
        do_req(1'b1, 4'h0, 9'd0, 32'h0,        4, 32'hA100C300);

        // Init phase: requests ignored, init writes land in one cycle
        @(posedge i_clk); #1;
        i_init_done = 1'b0;
        i_init_wen  = 4'hF;
        i_init_addr = 9'd7;
        i_init_data = 32'h12345678;
        i_ren       = 1'b1;
        i_addr      = 9'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check("init_stall", {31'd0, o_stall}, 32'd1);
            check("init_valid", {31'd0, o_valid}, 32'd0);
        end
        @(posedge i_clk); #1;
        i_ren       = 1'b0;
        i_init_wen  = '0;
        i_init_done = 1'b1;
        do_req(1'b1, 4'h0, 9'd7, 32'h0, 4, 32'h12345678);

        // Reset mid-write discards the transaction
        @(posedge i_clk); #1;
        i_wen  = 4'hF;
        i_addr = 9'd9;
        i_data = 32'hFFFFFFFF;
        @(negedge i_clk);
        check("abort_stall0", {31'd0, o_stall}, 32'd1);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        i_wen = '0;
        @(negedge i_clk);
        check("abort_valid_rst", {31'd0, o_valid}, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            check("abort_stall", {31'd0, o_stall}, 32'd0);
            check("abort_valid", {31'd0, o_valid}, 32'd0);
        end
        do_req(1'b1, 4'h0, 9'd9, 32'h0, 4, 32'h00000000);

        repeat (2) @(negedge i_clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
        $fatal(1);
    end

endmodule
